// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: request side (A/B/OP/in_valid/in_ready)
// and response side (alu_out/flags/out_valid/out_ready).
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       OP;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_out;
    logic [3:0]       flags;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output A, B, OP, in_valid, out_ready,
        input  in_ready, alu_out, flags, out_valid
    );

    modport slave (
        input  A, B, OP, in_valid, out_ready,
        output in_ready, alu_out, flags, out_valid
    );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle logic/arith ops, serial shifts (1 bit/cycle) and, with
// ALU_MUL_EN defined, a WIDTH-cycle shift-add multiply on opcode 15 (else all-ones).
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input logic     clk,
    input logic     rst,
    alu_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [3:0] OP_ZERO = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_RNOR = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_XNOR = 4'd8;
    localparam logic [3:0] OP_SLL  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;
    localparam logic [3:0] OP_RAND = 4'd11;
    localparam logic [3:0] OP_ROR  = 4'd12;
    localparam logic [3:0] OP_RNAN = 4'd13;
    localparam logic [3:0] OP_RXOR = 4'd14;
    localparam logic [3:0] OP_F    = 4'd15;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [3:0]       flg;   // {N,V,C,Z}
    } result_t;

    logic [0:0]       state;
    logic [SHW:0]     cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] sh_val;
    logic             ov_q;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       flg_q;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mul_acc;
    logic [2*WIDTH-1:0] mul_mcand;
    logic [WIDTH-1:0]   mul_mplier;
    logic [2*WIDTH-1:0] mul_acc_nx;
`endif

    logic             out_free;
    logic             accept;
    logic             multi;
    logic             busy_step;
    logic             busy_done;
    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] sh_next;
    logic             sh_out;
    result_t          sc;
    result_t          bz;

    assign out_free      = !ov_q || bus.out_ready;
    assign bus.in_ready  = (state == S_IDLE) && out_free;
    assign accept        = bus.in_valid && bus.in_ready;
    assign amt           = bus.B[SHW-1:0];
    assign bus.alu_out   = res_q;
    assign bus.flags     = flg_q;
    assign bus.out_valid = ov_q;

    // The busy path only advances when the output slot is free, so a result is never dropped.
    assign busy_step = (state == S_BUSY) && out_free;
    assign busy_done = busy_step && (cnt == (SHW+1)'(1));

    always_comb begin
        multi = 1'b0;
        if ((bus.OP == OP_SLL || bus.OP == OP_SRL) && amt != '0)
            multi = 1'b1;
`ifdef ALU_MUL_EN
        if (bus.OP == OP_F)
            multi = 1'b1;
`endif
    end

    // Single-cycle results, including zero-amount shifts.
    always_comb begin
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        add_w = {1'b0, bus.A} + {1'b0, bus.B};
        sub_w = {1'b0, bus.A} - {1'b0, bus.B};
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (bus.OP)
            OP_ZERO: r = '0;
            OP_ADD: begin
                r = add_w[WIDTH-1:0];
                c = add_w[WIDTH];
                v = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (r[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                r = sub_w[WIDTH-1:0];
                c = sub_w[WIDTH];
                v = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (r[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND:  r = bus.A & bus.B;
            OP_OR:   r = bus.A | bus.B;
            OP_NOT:  r = ~bus.A;
            OP_RNOR: r = {{(WIDTH-1){1'b0}}, ~|bus.A};
            OP_XOR:  r = bus.A ^ bus.B;
            OP_XNOR: r = bus.A ~^ bus.B;
            OP_SLL:  r = bus.A;
            OP_SRL:  r = bus.A;
            OP_RAND: r = {{(WIDTH-1){1'b0}}, &bus.A};
            OP_ROR:  r = {{(WIDTH-1){1'b0}}, |bus.A};
            OP_RNAN: r = {{(WIDTH-1){1'b0}}, ~&bus.A};
            OP_RXOR: r = {{(WIDTH-1){1'b0}}, ^bus.A};
            OP_F:    r = '1;
            default: r = '0;
        endcase
        sc.res = r;
        sc.flg = {r[WIDTH-1], v, c, (r == '0)};
    end

    always_comb begin
        if (op_q == OP_SLL) begin
            sh_next = {sh_val[WIDTH-2:0], 1'b0};
            sh_out  = sh_val[WIDTH-1];
        end else begin
            sh_next = {1'b0, sh_val[WIDTH-1:1]};
            sh_out  = sh_val[0];
        end
    end

`ifdef ALU_MUL_EN
    assign mul_acc_nx = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
`endif

    // Result of the final busy step; carry is the bit leaving on that step.
    always_comb begin
        logic [WIDTH-1:0] r;
        logic             c;
        r = sh_next;
        c = sh_out;
`ifdef ALU_MUL_EN
        if (op_q == OP_F) begin
            r = mul_acc_nx[WIDTH-1:0];
            c = |mul_acc_nx[2*WIDTH-1:WIDTH];
        end
`endif
        bz.res = r;
        bz.flg = {r[WIDTH-1], 1'b0, c, (r == '0)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            sh_val <= '0;
            ov_q   <= 1'b0;
            res_q  <= '0;
            flg_q  <= '0;
`ifdef ALU_MUL_EN
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
`endif
        end else begin
            if (accept) begin
                op_q <= bus.OP;
                if (multi) begin
                    state  <= S_BUSY;
                    sh_val <= bus.A;
                    cnt    <= {1'b0, amt};
`ifdef ALU_MUL_EN
                    if (bus.OP == OP_F)
                        cnt <= (SHW+1)'(WIDTH);
                    mul_acc    <= '0;
                    mul_mcand  <= {{WIDTH{1'b0}}, bus.A};
                    mul_mplier <= bus.B;
`endif
                end
            end else if (busy_step) begin
                sh_val <= sh_next;
                cnt    <= cnt - (SHW+1)'(1);
`ifdef ALU_MUL_EN
                mul_acc    <= mul_acc_nx;
                mul_mcand  <= {mul_mcand[2*WIDTH-2:0], 1'b0};
                mul_mplier <= {1'b0, mul_mplier[WIDTH-1:1]};
`endif
                if (busy_done)
                    state <= S_IDLE;
            end

            if (accept && !multi) begin
                res_q <= sc.res;
                flg_q <= sc.flg;
                ov_q  <= 1'b1;
            end else if (busy_done) begin
                res_q <= bz.res;
                flg_q <= bz.flg;
                ov_q  <= 1'b1;
            end else if (bus.out_ready) begin
                ov_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8) with an arithmetic reference model and scoreboard.
module tb_alu_pipe;
    logic clk;
    logic rst;

    alu_pipe_if #(.WIDTH(8)) ifc ();

    alu_pipe #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] flg;
    } exp_t;

    exp_t q_exp[$];
    int   n_chk  = 0;
    int   n_fail = 0;

`ifdef ALU_MUL_EN
    localparam int MUL_BUSY = 8;
`else
    localparam int MUL_BUSY = 0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode's definition.
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, amt, t, ones;
        logic [7:0] r;
        logic c, v;
        exp_t e;
        ua = int'(a); ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        amt = ub % 8;
        r = 8'h00; c = 1'b0; v = 1'b0;
        case (op)
            4'd1: begin t = ua + ub; r = 8'(t); c = (t > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            4'd2: begin t = ua - ub; r = 8'(t); c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = ~a;
            4'd6: r = (ua == 0) ? 8'd1 : 8'd0;
            4'd7: r = a ^ b;
            4'd8: r = ~(a ^ b);
            4'd9: begin t = ua * (1 << amt); r = 8'(t); c = (amt != 0) && ((t / 256) % 2 == 1); end
            4'd10: begin r = 8'(ua / (1 << amt)); c = (amt != 0) && (((ua / (1 << (amt - 1))) % 2) == 1); end
            4'd11: r = (ua == 255) ? 8'd1 : 8'd0;
            4'd12: r = (ua != 0) ? 8'd1 : 8'd0;
            4'd13: r = (ua != 255) ? 8'd1 : 8'd0;
            4'd14: begin
                ones = 0;
                for (int i = 0; i < 8; i++) ones += (ua / (1 << i)) % 2;
                r = 8'(ones % 2);
            end
`ifdef ALU_MUL_EN
            4'd15: begin t = ua * ub; r = 8'(t); c = (t > 255); end
`else
            4'd15: r = 8'hFF;
`endif
            default: r = 8'h00;
        endcase
        e.res = r;
        e.flg = {r[7], v, c, (r == 8'h00)};
        return e;
    endfunction

    // Called at posedge+#1; holds the op until the cycle it is accepted.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output int waits);
        bit acc;
        acc = 0;
        waits = 0;
        ifc.OP = op; ifc.A = a; ifc.B = b; ifc.in_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            if (ifc.in_ready) begin
                q_exp.push_back(model(op, a, b));
                acc = 1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        ifc.in_valid = 1'b0;
        if (!acc) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: op %0d never accepted", op);
        end
    endtask

    // Scoreboard compare on every cycle a result is presented.
    always @(negedge clk) begin
        if (!rst && ifc.out_valid) begin
            if (q_exp.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_result: got %0h/%0h expected none pending", ifc.alu_out, ifc.flags);
            end else begin
                check("scoreboard", 32'({ifc.alu_out, ifc.flags}), 32'({q_exp[0].res, q_exp[0].flg}));
                if (ifc.out_ready) q_exp.delete(0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Latency probe: busy cycles with in_ready low and nothing presented, then the result.
    task automatic probe_latency(input string name, input int busy, input logic [7:0] er, input logic [3:0] ef);
        for (int i = 0; i < busy; i++) begin
            @(negedge clk);
            check({name, "_busy_rdy"}, 32'(ifc.in_ready), 32'd0);
            check({name, "_busy_ov"}, 32'(ifc.out_valid), 32'd0);
        end
        @(negedge clk);
        check({name, "_ov"}, 32'(ifc.out_valid), 32'd1);
        check({name, "_out"}, 32'(ifc.alu_out), 32'(er));
        check({name, "_flags"}, 32'(ifc.flags), 32'(ef));
        @(posedge clk); #1;
    endtask

    logic [3:0] vop [16] = '{4'd0, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd7, 4'd8,
                             4'd11, 4'd12, 4'd13, 4'd14, 4'd9, 4'd10, 4'd1, 4'd2};
    logic [7:0] va  [16] = '{8'h5A, 8'hF0, 8'hF0, 8'h0F, 8'h00, 8'h01, 8'hAA, 8'hAA,
                             8'hFF, 8'h00, 8'hFF, 8'h07, 8'h81, 8'h01, 8'h7F, 8'h00};
    logic [7:0] vb  [16] = '{8'h3C, 8'h3C, 8'h0F, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h0F,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h01, 8'h01};
    logic [3:0] mop [5]  = '{4'd10, 4'd9, 4'd10, 4'd9, 4'd15};
    logic [7:0] ma  [5]  = '{8'hF0, 8'hFF, 8'h80, 8'h01, 8'hFF};
    logic [7:0] mb  [5]  = '{8'h05, 8'h07, 8'h07, 8'h01, 8'hFF};

    initial begin
        int w;
        exp_t e;
        rst = 1'b1;
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
        ifc.A = '0; ifc.B = '0; ifc.OP = '0;

        // Pin the model against hand-computed values.
        e = model(4'd1, 8'hFF, 8'h01);  check("model_add", 32'(e), 32'({8'h00, 4'b0011}));
        e = model(4'd2, 8'h80, 8'h01);  check("model_sub", 32'(e), 32'({8'h7F, 4'b0100}));
        e = model(4'd10, 8'hF0, 8'h05); check("model_srl", 32'(e), 32'({8'h07, 4'b0010}));
        e = model(4'd9, 8'h81, 8'h03);  check("model_sll", 32'(e), 32'({8'h08, 4'b0000}));
        e = model(4'd15, 8'd13, 8'd11);
`ifdef ALU_MUL_EN
        check("model_mul", 32'(e), 32'({8'h8F, 4'b1000}));
`else
        check("model_ones", 32'(e), 32'({8'hFF, 4'b1000}));
`endif

        repeat (2) @(posedge clk);
        #2;
        check("rst_ov", 32'(ifc.out_valid), 32'd0);
        check("rst_out", 32'(ifc.alu_out), 32'd0);
        check("rst_flags", 32'(ifc.flags), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(ifc.in_ready), 32'd1);
        @(posedge clk); #1;

        // Add wrap with carry, then sub overflow.
        send(4'd1, 8'hFF, 8'h01, w);
        probe_latency("add", 0, 8'h00, 4'b0011);
        send(4'd2, 8'h80, 8'h01, w);
        probe_latency("sub", 0, 8'h7F, 4'b0100);

        // Serial shift left by 3.
        send(4'd9, 8'h81, 8'h03, w);
        probe_latency("sll3", 3, 8'h08, 4'b0000);

        // Stalled consumer: result held, no acceptance; released in the same cycle.
        ifc.out_ready = 1'b0;
        send(4'd7, 8'h5A, 8'h0F, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_out", 32'(ifc.alu_out), 32'h55);
            check("stall_rdy", 32'(ifc.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        ifc.out_ready = 1'b1;
        #1;
        check("release_rdy", 32'(ifc.in_ready), 32'd1);
        @(posedge clk); #1;

        // Opcode 15.
        send(4'd15, 8'd13, 8'd11, w);
`ifdef ALU_MUL_EN
        probe_latency("op15", MUL_BUSY, 8'h8F, 4'b1000);
`else
        probe_latency("op15", MUL_BUSY, 8'hFF, 4'b1000);
`endif

        // Back-to-back single-cycle ops: accepted every cycle.
        for (int i = 0; i < 16; i++) begin
            send(vop[i], va[i], vb[i], w);
            check("b2b_wait", 32'(w), 32'd0);
        end

        // Multi-cycle ops, checked by the scoreboard.
        for (int i = 0; i < 5; i++) send(mop[i], ma[i], mb[i], w);
        repeat (12) @(posedge clk);
        #1;

        // in_valid during BUSY is ignored.
        send(4'd10, 8'hF0, 8'h05, w);
        ifc.OP = 4'd1; ifc.A = 8'h01; ifc.B = 8'h01; ifc.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("busy_ignore_drained", 32'(q_exp.size()), 32'd0);

        // Reset in the 2nd BUSY cycle aborts the shift.
        send(4'd10, 8'hF0, 8'h05, w);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_ov", 32'(ifc.out_valid), 32'd0);
        check("abort_out", 32'(ifc.alu_out), 32'd0);
        check("abort_idle", 32'(ifc.in_ready), 32'd1);
        #1;
        rst = 1'b0;
        q_exp.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_result", 32'(ifc.out_valid), 32'd0);
        end
        @(posedge clk); #1;

        repeat (4) @(posedge clk);
        check("final_drained", 32'(q_exp.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the operand and result width in bits, power of two, 4..64.
REQ-002 The block SHALL have derived localparam SHW = clog2(WIDTH), which sets the width of the shift-amount field.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL change on the rising edge of clk.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port A, input, WIDTH bits: operand A.
REQ-006 Port B, input, WIDTH bits: operand B.
REQ-007 Port OP, input, 4 bits: opcode.
REQ-008 Port in_valid, input, 1 bit: the A/B/OP inputs carry a valid operation.
REQ-009 Port in_ready, output, 1 bit: the block can accept an operation this cycle.
REQ-010 Port alu_out, output, WIDTH bits: registered result.
REQ-011 Port flags, output, 4 bits: registered flags {N,V,C,Z}.
REQ-012 Port out_valid, output, 1 bit: alu_out and flags hold an unconsumed result.
REQ-013 Port out_ready, input, 1 bit: the consumer takes the result this cycle.

Function
REQ-014 An operation SHALL be accepted on a clock edge where in_valid && in_ready; A, B and OP SHALL be captured at acceptance and ignored otherwise.
REQ-015 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-016 The state machine SHALL have states IDLE, BUSY and IDLE->BUSY, entered only on acceptance of a multi-cycle operation with nonzero count; BUSY->IDLE SHALL occur on the edge where the result is written.
REQ-017 Opcodes: 0 zero; 1 A+B; 2 A-B; 3 A&B; 4 A|B; 5 ~A; 6 ~|A; 7 A^B; 8 A~^B; 9 shift left logical; 10 shift right logical; 11 &A; 12 |A; 13 ~&A; 14 ^A; 15 all-ones (see Configuration).
REQ-018 Reduction results (opcodes 6 and 11-14) SHALL be zero-extended to WIDTH.
REQ-019 Single-cycle ops SHALL be written to alu_out/flags with out_valid=1 on the edge after acceptance (latency 1).
REQ-020 Shifts SHALL move A by amount B[SHW-1:0], one bit per cycle in BUSY, zero fill; latency = max(1, amount) cycles; amount 0 SHALL return A with C=0.
REQ-021 Z SHALL be 1 when the result is 0.
REQ-022 N SHALL equal result[WIDTH-1].
REQ-023 C SHALL be: carry-out for add; borrow (A<B unsigned) for sub; last bit shifted out for shifts; 0 for all other ops.
REQ-024 V SHALL be two's-complement overflow for add/sub and 0 for all other ops.
REQ-025 Arithmetic SHALL wrap modulo 2^WIDTH.
REQ-026 While out_valid && !out_ready, alu_out/flags SHALL hold and no new result SHALL be written.
REQ-027 out_valid SHALL clear on out_ready unless a new result is written on the same edge (back-to-back throughput of 1 op/cycle for single-cycle ops).
REQ-028 in_valid asserted during BUSY SHALL be ignored; no operation SHALL be queued.

Reset
REQ-029 On rst high, state SHALL go to IDLE, out_valid=0, alu_out=0, flags=0, shift/multiply counters=0, immediately and independently of clk.
REQ-030 rst asserted mid-operation SHALL abort the operation and discard it without producing a result.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-032 With macro ALU_MUL_EN defined, opcode 15 SHALL be an unsigned multiply returning the low WIDTH bits of A*B via shift-add, BUSY for exactly WIDTH cycles, with C=1 if any high product bit is nonzero and V=0.
REQ-033 With ALU_MUL_EN undefined, opcode 15 SHALL return all-ones in 1 cycle with C=V=0 and no multiplier logic present.

Verification (WIDTH=8)
REQ-034 OP=1, A=0xFF, B=0x01 -> next cycle alu_out=0x00, flags Z=1 C=1 V=0 N=0, out_valid=1.
REQ-035 OP=2, A=0x80, B=0x01 -> alu_out=0x7F, V=1, C=0, N=0, Z=0.
REQ-036 OP=9, A=0x81, B=0x03 -> in_ready low 3 cycles, then alu_out=0x08, C=0, Z=0.
REQ-037 OP=7 result with out_ready held low 3 cycles -> alu_out stable, in_ready=0; out_ready high -> in_ready=1 the same cycle.
REQ-038 OP=10, A=0xF0, B=0x05, rst pulsed in the 2nd BUSY cycle -> out_valid=0, alu_out=0, IDLE, no result emitted afterwards.
REQ-039 OP=15, A=13, B=11 -> with ALU_MUL_EN: alu_out=0x8F after 8 cycles, C=0; without ALU_MUL_EN: alu_out=0xFF after 1 cycle.
